// File: rtl/mp1_cpu.sv
// Multicycle 16-bit LC-3b-subset core: one instruction at a time through a single
// shared req/resp memory port (word-aligned, byte-addressed).
//
// state     | meaning
// FETCH1    | MAR <= PC, PC <= PC+2
// FETCH2    | instruction read pending, MDR <= rdata on resp
// FETCH3    | IR <= MDR
// DECODE    | execute ALU/BR/JMP/LEA/NOP, or go compute an LDR/STR address
// CALC_ADDR | MAR <= BaseR + (sext(offset6) << 1)
// LDR1      | data read pending, MDR <= rdata on resp
// LDR2      | DR <= MDR, update CC
// STR1      | MDR <= SR
// STR2      | data write pending until resp
module mp1_cpu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata
);

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [2:0]  cc_q, cc_d;
  logic [15:0] rf_q [8];

  logic        rf_we;
  logic [15:0] rf_wdata;

  logic [3:0]  opcode;
  logic [15:0] sr1_val, sr2_val, dr_val;
  logic [15:0] imm5, off6, off9;
  logic [15:0] alu_b, alu_res;

  assign opcode  = ir_q[15:12];
  assign sr1_val = rf_q[ir_q[8:6]];
  assign sr2_val = rf_q[ir_q[2:0]];
  assign dr_val  = rf_q[ir_q[11:9]];
  assign imm5    = {{11{ir_q[4]}}, ir_q[4:0]};
  assign off6    = {{9{ir_q[5]}}, ir_q[5:0], 1'b0};
  assign off9    = {{6{ir_q[8]}}, ir_q[8:0], 1'b0};
  assign alu_b   = ir_q[5] ? imm5 : sr2_val;

  // {N,Z,P}, same bit order as the BR nzp field
  function automatic logic [2:0] cc_of(input logic [15:0] r);
    return {r[15], (r == 16'h0000), (!r[15] && (r != 16'h0000))};
  endfunction

  always_comb begin
    alu_res = ~sr1_val;
    if (opcode == OP_ADD)      alu_res = sr1_val + alu_b;
    else if (opcode == OP_AND) alu_res = sr1_val & alu_b;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    cc_d     = cc_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    unique case (state_q)
      FETCH1: begin
        mar_d   = pc_q;
        pc_d    = pc_q + 16'd2;
        state_d = FETCH2;
      end
      FETCH2: begin
        if (mem_resp) begin
          mdr_d   = mem_rdata;
          state_d = FETCH3;
        end
      end
      FETCH3: begin
        ir_d    = mdr_q;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = FETCH1;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_we    = 1'b1;
            rf_wdata = alu_res;
            cc_d     = cc_of(alu_res);
          end
          OP_BR:  if (|(ir_q[11:9] & cc_q)) pc_d = pc_q + off9;
          OP_LDR, OP_STR: state_d = CALC_ADDR;
          OP_JMP: pc_d = sr1_val;
          OP_LEA: begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + off9;
          end
          default: ;
        endcase
      end
      CALC_ADDR: begin
        mar_d   = sr1_val + off6;
        state_d = (opcode == OP_LDR) ? LDR1 : STR1;
      end
      LDR1: begin
        if (mem_resp) begin
          mdr_d   = mem_rdata;
          state_d = LDR2;
        end
      end
      LDR2: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        cc_d     = cc_of(mdr_q);
        state_d  = FETCH1;
      end
      STR1: begin
        mdr_d   = dr_val;
        state_d = STR2;
      end
      STR2: begin
        if (mem_resp) state_d = FETCH1;
      end
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH1;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      cc_q    <= 3'b010;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cc_q    <= cc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[ir_q[11:9]] <= rf_wdata;
    end
  end

  assign mem_read        = (state_q == FETCH2) || (state_q == LDR1);
  assign mem_write       = (state_q == STR2);
  assign mem_byte_enable = 2'b11;
  assign mem_address     = mar_q;
  assign mem_wdata       = mdr_q;

endmodule

// File: tb/tb_mp1_cpu.sv
// Bench for mp1_cpu: directed and random programs run against an ISA-level model;
// the observed memory transaction stream and final memory image are compared.
module tb_mp1_cpu;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;

  logic [15:0] mem_arr [0:32767];
  logic [15:0] ref_mem [0:32767];
  txn_t        obs_q[$];
  txn_t        exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int delay_cfg = 0;
  bit rnd_delay = 1'b0;
  int wait_cnt = 0;
  int cur_dly  = 0;
  int be_err   = 0;
  int stab_err = 0;
  int both_err = 0;
  int wp;

  logic        pend_q = 1'b0;
  logic [15:0] pend_addr, pend_wdata;
  logic [1:0]  pend_kind;

  mp1_cpu #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_address[15:1]];
  assign mem_resp  = (mem_read || mem_write) && (wait_cnt >= cur_dly);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      cur_dly  <= delay_cfg;
    end else if (mem_resp) begin
      obs_q.push_back(mk_txn(mem_write, mem_address, mem_write ? mem_wdata : mem_rdata));
      if (mem_write) begin
        mem_arr[mem_address[15:1]] = mem_wdata;
        if (mem_byte_enable != 2'b11) be_err++;
      end
      wait_cnt <= 0;
      cur_dly  <= rnd_delay ? int'($urandom_range(0, 3)) : delay_cfg;
    end else if (mem_read || mem_write) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q = 1'b0;
    end else begin
      if (mem_read && mem_write) both_err++;
      if (pend_q && (mem_address != pend_addr || mem_wdata != pend_wdata ||
                     {mem_read, mem_write} != pend_kind)) stab_err++;
      pend_q     = (mem_read || mem_write) && !mem_resp;
      pend_addr  = mem_address;
      pend_wdata = mem_wdata;
      pend_kind  = {mem_read, mem_write};
    end
  end

  function automatic txn_t mk_txn(input logic wr, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_alu_i(input logic [3:0] op, input int dr, input int sr, input int imm);
    return {op, 3'(dr), 3'(sr), 1'b1, 5'(imm)};
  endfunction
  function automatic logic [15:0] enc_alu_r(input logic [3:0] op, input int dr, input int sr1, input int sr2);
    return {op, 3'(dr), 3'(sr1), 3'b000, 3'(sr2)};
  endfunction
  function automatic logic [15:0] enc_not(input int dr, input int sr);
    return {4'h9, 3'(dr), 3'(sr), 6'h3F};
  endfunction
  function automatic logic [15:0] enc_br(input int nzp, input int off);
    return {4'h0, 3'(nzp), 9'(off)};
  endfunction
  function automatic logic [15:0] enc_mem(input logic [3:0] op, input int r, input int base, input int off);
    return {op, 3'(r), 3'(base), 6'(off)};
  endfunction
  function automatic logic [15:0] enc_lea(input int dr, input int off);
    return {4'hE, 3'(dr), 9'(off)};
  endfunction
  function automatic logic [15:0] enc_jmp(input int base);
    return {4'hC, 3'b000, 3'(base), 6'h00};
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    else if (v == 16'h0000) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic emit(input logic [15:0] w);
    mem_arr[wp] = w;
    wp++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'h0000;
    wp = 0;
  endtask

  // ISA-level reference: executes from ref_mem until an instruction branches to itself
  task automatic model_run();
    logic [15:0] r [8];
    logic [15:0] pc, pc0, ir, a, b, res, sext9;
    logic [2:0]  cc;
    pc = 16'h0000;
    cc = 3'b010;
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    for (int k = 0; k < 4000; k++) begin
      pc0 = pc;
      ir  = ref_mem[pc0[15:1]];
      exp_q.push_back(mk_txn(1'b0, pc0, ir));
      pc    = pc0 + 16'd2;
      sext9 = 16'($signed(ir[8:0]));
      case (ir[15:12])
        4'h1, 4'h5, 4'h9: begin
          b = ir[5] ? 16'($signed(ir[4:0])) : r[ir[2:0]];
          if (ir[15:12] == 4'h1)      res = r[ir[8:6]] + b;
          else if (ir[15:12] == 4'h5) res = r[ir[8:6]] & b;
          else                        res = ~r[ir[8:6]];
          r[ir[11:9]] = res;
          cc = nzp_of(res);
        end
        4'h0: if ((ir[11] && cc == 3'b100) || (ir[10] && cc == 3'b010) || (ir[9] && cc == 3'b001))
                pc = pc + sext9 * 16'd2;
        4'h6: begin
          a   = r[ir[8:6]] + 16'($signed(ir[5:0])) * 16'd2;
          res = ref_mem[a[15:1]];
          exp_q.push_back(mk_txn(1'b0, a, res));
          r[ir[11:9]] = res;
          cc = nzp_of(res);
        end
        4'h7: begin
          a = r[ir[8:6]] + 16'($signed(ir[5:0])) * 16'd2;
          exp_q.push_back(mk_txn(1'b1, a, r[ir[11:9]]));
          ref_mem[a[15:1]] = r[ir[11:9]];
        end
        4'hC: pc = r[ir[8:6]];
        4'hE: r[ir[11:9]] = pc + sext9 * 16'd2;
        default: ;
      endcase
      if (pc == pc0) begin
        exp_q.push_back(mk_txn(1'b0, pc0, ref_mem[pc0[15:1]]));
        break;
      end
    end
  endtask

  task automatic run_prog(input string name, input int dly, input bit rnd);
    int cyc;
    int diffs;
    delay_cfg = dly;
    rnd_delay = rnd;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 32768; i++) ref_mem[i] = mem_arr[i];
    model_run();
    rst_n = 1'b1;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "_done"}, 64'(obs_q.size() >= exp_q.size()), 64'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs_q.size()) break;
      check_eq({name, "_txn"}, 64'(obs_q[i]), 64'(exp_q[i]));
      if (obs_q[i] !== exp_q[i]) break;
    end
    diffs = 0;
    for (int i = 0; i < 32768; i++) if (mem_arr[i] !== ref_mem[i]) diffs++;
    check_eq({name, "_mem"}, 64'(diffs), 64'd0);
  endtask

  task automatic load_prog_a();
    clear_mem();
    emit(enc_alu_i(4'h5, 0, 0, 0));
    emit(enc_alu_i(4'h1, 1, 0, 5));
    emit(enc_alu_i(4'h1, 2, 1, -7));
    emit(enc_br(3'b100, 1));
    emit(enc_alu_i(4'h1, 0, 0, 1));
    emit(enc_not(3, 2));
    emit(enc_lea(1, (16'h0100 - wp * 2 - 2) / 2));
    emit(enc_mem(4'h6, 4, 1, 2));
    emit(enc_mem(4'h6, 5, 1, 3));
    emit(enc_mem(4'h7, 5, 1, -1));
    emit(enc_mem(4'h7, 2, 1, 4));
    emit(enc_mem(4'h7, 3, 1, 5));
    emit(enc_mem(4'h7, 4, 1, 6));
    emit(enc_br(3'b111, -1));
    mem_arr[16'h0104 >> 1] = 16'hBEEF;
    mem_arr[16'h0106 >> 1] = 16'h1234;
  endtask

  task automatic check_prog_a(input string name);
    check_eq({name, "_first"},  64'(obs_q[0]), 64'(mk_txn(1'b0, 16'h0000, 16'h5020)));
    check_eq({name, "_ldr"},    64'(obs_q[7]), 64'(mk_txn(1'b0, 16'h0104, 16'hBEEF)));
    check_eq({name, "_str_r5"}, 64'(mem_arr[16'h00FE >> 1]), 64'h1234);
    check_eq({name, "_r2"},     64'(mem_arr[16'h0108 >> 1]), 64'hFFFE);
    check_eq({name, "_r3"},     64'(mem_arr[16'h010A >> 1]), 64'h0001);
    check_eq({name, "_r4"},     64'(mem_arr[16'h010C >> 1]), 64'hBEEF);
  endtask

  task automatic load_random(input int n);
    logic [3:0] nop_ops [8];
    nop_ops = '{4'h2, 4'h3, 4'h4, 4'h8, 4'hA, 4'hB, 4'hD, 4'hF};
    clear_mem();
    for (int i = 16'h0EC0 >> 1; i <= (16'h0F3E >> 1); i++) mem_arr[i] = 16'($urandom);
    emit(enc_alu_i(4'h5, 7, 7, 0));
    emit(enc_alu_i(4'h1, 7, 7, 15));
    for (int i = 0; i < 8; i++) emit(enc_alu_r(4'h1, 7, 7, 7));
    for (int i = 0; i < n; i++) begin
      int dr, s1;
      dr = int'($urandom_range(0, 6));
      s1 = int'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: emit(enc_alu_i(4'h1, dr, s1, int'($urandom_range(0, 31))));
        1: emit(enc_alu_r(4'h1, dr, s1, int'($urandom_range(0, 7))));
        2: emit(enc_alu_i(4'h5, dr, s1, int'($urandom_range(0, 31))));
        3: emit(enc_alu_r(4'h5, dr, s1, int'($urandom_range(0, 7))));
        4: emit(enc_not(dr, s1));
        5: emit(enc_mem(4'h6, dr, 7, int'($urandom_range(0, 63))));
        6: emit(enc_mem(4'h7, s1, 7, int'($urandom_range(0, 63))));
        7: emit(enc_br(int'($urandom_range(0, 7)), int'($urandom_range(0, 3))));
        8: emit(enc_lea(dr, int'($urandom_range(0, 511))));
        default: emit({nop_ops[$urandom_range(0, 7)], 12'($urandom)});
      endcase
    end
    for (int i = 0; i < 4; i++) emit(enc_br(3'b111, -1));
  endtask

  initial begin
    int cyc, nwr;
    #1;
    check_eq("rst_read",  64'(mem_read),        64'd0);
    check_eq("rst_write", 64'(mem_write),       64'd0);
    check_eq("rst_addr",  64'(mem_address),     64'd0);
    check_eq("rst_wdata", 64'(mem_wdata),       64'd0);
    check_eq("rst_be",    64'(mem_byte_enable), 64'd3);

    load_prog_a();
    run_prog("a_w0", 0, 1'b0);
    check_prog_a("a_w0");
    load_prog_a();
    run_prog("a_w3", 3, 1'b0);
    check_prog_a("a_w3");

    clear_mem();
    emit(enc_alu_i(4'h5, 0, 0, 0));
    mem_arr[8] = enc_br(3'b010, -1);
    run_prog("brz", 0, 1'b0);
    check_eq("brz_refetch", 64'(obs_q[9].addr), 64'h0010);

    clear_mem();
    emit(enc_alu_i(4'h5, 0, 0, 0));
    mem_arr[8] = enc_br(3'b001, -1);
    mem_arr[9] = enc_br(3'b111, -1);
    run_prog("brp", 0, 1'b0);
    check_eq("brp_fallthru", 64'(obs_q[9].addr), 64'h0012);

    clear_mem();
    emit(enc_lea(6, 3));
    emit(enc_jmp(6));
    emit(enc_alu_i(4'h1, 0, 0, 1));
    emit(enc_alu_i(4'h1, 0, 0, 1));
    emit(enc_br(3'b111, -1));
    run_prog("jmp", 1, 1'b0);
    check_eq("jmp_target", 64'(obs_q[2].addr), 64'h0008);

    load_random(300);
    run_prog("rand_w0", 0, 1'b0);
    load_random(300);
    run_prog("rand_w3", 3, 1'b0);
    load_random(300);
    run_prog("rand_wr", 0, 1'b1);

    // reset pulsed while a store is waiting for its response
    clear_mem();
    emit(enc_lea(1, 16'h40));
    emit(enc_mem(4'h7, 1, 1, 0));
    emit(enc_br(3'b111, -1));
    mem_arr[16'h0082 >> 1] = 16'hAAAA;
    delay_cfg = 3;
    rnd_delay = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    obs_q.delete();
    rst_n = 1'b1;
    cyc = 0;
    while (!mem_write && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_str_reached", 64'(mem_write), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_write", 64'(mem_write),   64'd0);
    check_eq("rst_mid_read",  64'(mem_read),    64'd0);
    check_eq("rst_mid_addr",  64'(mem_address), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nwr = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) nwr++;
    check_eq("rst_no_write",  64'(nwr), 64'd0);
    check_eq("rst_mem_intact", 64'(mem_arr[16'h0082 >> 1]), 64'hAAAA);
    obs_q.delete();
    rst_n = 1'b1;
    cyc = 0;
    while (obs_q.size() < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_restart", 64'(obs_q[0]), 64'(mk_txn(1'b0, 16'h0000, enc_lea(1, 16'h40))));

    check_eq("byte_enable", 64'(be_err),   64'd0);
    check_eq("req_stable",  64'(stab_err), 64'd0);
    check_eq("rd_wr_excl",  64'(both_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
